imdr_gen: RTL and testbench

Parametrised iterative integer multiply/divide/remainder unit for the IU execute stage, the next-generation replacement for the fixed 32-bit multi-cycle divider path. Accepts one mul/div/rem request from the decode stage. Computes it one bit per cycle with a shift-add or restoring-subtract datapath on operand magnitudes, then applies a sign fix-up. Over the current unit it adds width parametrisation, a `busy` indication, zero-operand early-out, and an optional unsigned mode.

---
 rtl/imdr_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_imdr_gen.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imdr_gen.sv
`default_nettype none
// ============================================================================
// Module   : imdr_gen
// Brief    : Iterative signed/unsigned multiply, divide and remainder unit,
//            one bit per cycle on operand magnitudes, then a sign fix-up.
//            Optional macro IMDR_GEN_UNSIGNED_EN honours ie_unsigned_d.
// Revision : 1.0 - initial release
// ============================================================================
module imdr_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             ie_mul_d,
    input  logic             ie_div_d,
    input  logic             ie_rem_d,
    input  logic             ie_unsigned_d,
    input  logic [WIDTH-1:0] ie_dataA_d,
    input  logic [WIDTH-1:0] ie_dataB_d,
    input  logic             kill_inst_e,
    input  logic             pj_hold,
    output logic             imdr_busy,
    output logic             imdr_done_e,
    output logic             imdr_div0_e,
    output logic [WIDTH-1:0] imdr_data_out
);

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_op_b;
    logic               r_is_mul;
    logic               r_is_rem;
    logic               r_neg;
    logic               r_div0;
    logic [WIDTH-1:0]   r_data_out;

    // ------------------------------------------------------------------
    // Request decode and operand conditioning
    // ------------------------------------------------------------------
    logic               w_req;
    logic               w_accept;
    logic               w_kill;
    logic               w_div_op;
    logic               w_a_zero;
    logic               w_b_zero;
    logic               w_special;
    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic               w_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    assign w_req    = ie_mul_d | ie_div_d | ie_rem_d;
    assign w_accept = (r_state == ST_IDLE) & w_req & ~pj_hold & ~kill_inst_e;
    assign w_kill   = kill_inst_e & (r_state != ST_IDLE);
    assign w_div_op = ie_div_d | ie_rem_d;
    assign w_a_zero = (ie_dataA_d == '0);
    assign w_b_zero = (ie_dataB_d == '0);
    // Any zero operand short-circuits: B=0 is div0 for div/rem, zero result otherwise.
    assign w_special = w_a_zero | w_b_zero;

`ifdef IMDR_GEN_UNSIGNED_EN
    assign w_signed = ~ie_unsigned_d;
`else
    assign w_signed = 1'b1;
`endif

    assign w_sign_a = w_signed & ie_dataA_d[WIDTH-1];
    assign w_sign_b = w_signed & ie_dataB_d[WIDTH-1];
    assign w_neg    = ie_rem_d ? w_sign_a : (w_sign_a ^ w_sign_b);
    assign w_abs_a  = w_sign_a ? (~ie_dataA_d + WIDTH'(1)) : ie_dataA_d;
    assign w_abs_b  = w_sign_b ? (~ie_dataB_d + WIDTH'(1)) : ie_dataB_d;

    // ------------------------------------------------------------------
    // Iteration datapath: shift-add multiply, restoring divide
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_trial;
    logic               w_cout;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic [WIDTH-1:0]   w_fix_mag;
    logic [WIDTH-1:0]   w_fix_res;
    logic [1:0]         w_unused_bits;

    assign w_addend = r_lo[0] ? r_op_b : '0;
    assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    // WIDTH+1-bit subtract; carry-out set means the divisor fits.
    assign w_trial  = {1'b0, w_shift} + {1'b0, ~{1'b0, r_op_b}} + (WIDTH+2)'(1);
    assign w_cout   = w_trial[WIDTH+1];

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_is_mul) begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end else begin
            w_hi_nxt = w_cout ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_cout};
        end
    end

    assign w_fix_mag = r_is_rem ? r_hi : r_lo;
    assign w_fix_res = r_neg ? (~w_fix_mag + WIDTH'(1)) : w_fix_mag;

    // The remainder never exceeds WIDTH bits, so the adder's bit WIDTH is dropped.
    assign w_unused_bits = {ie_unsigned_d, w_trial[WIDTH]};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_kill) begin
            w_state_nxt = ST_IDLE;
        end else if (!pj_hold) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = w_special ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_FIX;
                    end
                end
                ST_FIX:  w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_op_b     <= '0;
            r_is_mul   <= 1'b0;
            r_is_rem   <= 1'b0;
            r_neg      <= 1'b0;
            r_div0     <= 1'b0;
            r_data_out <= '0;
        end else if (w_kill) begin
            r_cnt  <= '0;
            r_div0 <= 1'b0;
        end else if (!pj_hold) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hi     <= '0;
                        r_lo     <= w_div_op ? w_abs_a : w_abs_b;
                        r_op_b   <= w_div_op ? w_abs_b : w_abs_a;
                        r_is_mul <= ie_mul_d;
                        r_is_rem <= ie_rem_d;
                        r_neg    <= w_neg;
                        r_div0   <= w_div_op & w_b_zero;
                        r_cnt    <= w_special ? '0 : c_cnt_load;
                        if (w_special) begin
                            r_data_out <= '0;
                        end
                    end
                end
                ST_CALC: begin
                    r_hi <= w_hi_nxt;
                    r_lo <= w_lo_nxt;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    r_data_out <= w_fix_res;
                end
                ST_DONE: begin
                    r_div0 <= 1'b0;
                end
                default: begin
                    r_div0 <= 1'b0;
                end
            endcase
        end
    end

    assign imdr_busy     = (r_state != ST_IDLE);
    assign imdr_done_e   = (r_state == ST_DONE);
    assign imdr_div0_e   = r_div0;
    assign imdr_data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_imdr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_imdr_gen
// Brief    : Directed self-checking bench for imdr_gen at WIDTH=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imdr_gen;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk;
    logic             reset_l;
    logic             ie_mul_d;
    logic             ie_div_d;
    logic             ie_rem_d;
    logic             ie_unsigned_d;
    logic [WIDTH-1:0] ie_dataA_d;
    logic [WIDTH-1:0] ie_dataB_d;
    logic             kill_inst_e;
    logic             pj_hold;
    logic             imdr_busy;
    logic             imdr_done_e;
    logic             imdr_div0_e;
    logic [WIDTH-1:0] imdr_data_out;

    int checks   = 0;
    int failures = 0;

    imdr_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_l       (reset_l),
        .ie_mul_d      (ie_mul_d),
        .ie_div_d      (ie_div_d),
        .ie_rem_d      (ie_rem_d),
        .ie_unsigned_d (ie_unsigned_d),
        .ie_dataA_d    (ie_dataA_d),
        .ie_dataB_d    (ie_dataB_d),
        .kill_inst_e   (kill_inst_e),
        .pj_hold       (pj_hold),
        .imdr_busy     (imdr_busy),
        .imdr_done_e   (imdr_done_e),
        .imdr_div0_e   (imdr_div0_e),
        .imdr_data_out (imdr_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end at a falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic m, input logic d, input logic r,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        ie_mul_d   = m;
        ie_div_d   = d;
        ie_rem_d   = r;
        ie_dataA_d = a;
        ie_dataB_d = b;
        step();
        ie_mul_d = 1'b0;
        ie_div_d = 1'b0;
        ie_rem_d = 1'b0;
    endtask

    // Latency counts rising edges from the request edge to the done cycle.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!imdr_done_e && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        step();
        step();
        checks++;
        if (imdr_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", imdr_busy); end
        checks++;
        if (imdr_done_e !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", imdr_done_e); end
        checks++;
        if (imdr_div0_e !== 1'b0) begin failures++; $display("FAIL reset_div0 got=%b exp=0", imdr_div0_e); end
        checks++;
        if (imdr_data_out !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", imdr_data_out); end
        reset_l = 1'b1;
        step();
    endtask

    task automatic test_mul();
        logic [WIDTH-1:0] va [5] = '{32'd7, 32'hFFFFFFFA, 32'h00010000, 32'h7FFFFFFF, 32'hFFFFFFFF};
        logic [WIDTH-1:0] vb [5] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00010000, 32'd2, 32'hFFFFFFFF};
        logic [WIDTH-1:0] ve [5] = '{32'hFFFFFFEB, 32'd42, 32'd0, 32'hFFFFFFFE, 32'd1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 1'b0, 1'b0, va[i], vb[i]);
            checks++;
            if (imdr_busy !== 1'b1) begin failures++; $display("FAIL mul_busy[%0d] got=%b exp=1", i, imdr_busy); end
            wait_done(lat);
            checks++;
            if (lat != 34) begin failures++; $display("FAIL mul_latency[%0d] got=%0d exp=34", i, lat); end
            checks++;
            if (imdr_data_out !== ve[i]) begin failures++; $display("FAIL mul_data[%0d] got=%h exp=%h", i, imdr_data_out, ve[i]); end
            checks++;
            if (imdr_div0_e !== 1'b0) begin failures++; $display("FAIL mul_div0[%0d] got=%b exp=0", i, imdr_div0_e); end
            step();
        end
    endtask

    task automatic test_divrem();
        logic             vr [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [WIDTH-1:0] va [10] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'hFFFFFF9C,
                                      32'hFFFFFF9C, 32'd7, 32'd7, 32'h80000000, 32'h80000000};
        logic [WIDTH-1:0] vb [10] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFF9,
                                      32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [WIDTH-1:0] ve [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'd14,
                                      32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 32'h80000000, 32'd0};
        int lat;
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, ~vr[i], vr[i], va[i], vb[i]);
            wait_done(lat);
            checks++;
            if (lat != 34) begin failures++; $display("FAIL divrem_latency[%0d] got=%0d exp=34", i, lat); end
            checks++;
            if (imdr_data_out !== ve[i]) begin failures++; $display("FAIL divrem_data[%0d] got=%h exp=%h", i, imdr_data_out, ve[i]); end
            checks++;
            if (imdr_div0_e !== 1'b0) begin failures++; $display("FAIL divrem_div0[%0d] got=%b exp=0", i, imdr_div0_e); end
            step();
        end
    endtask

    task automatic test_special();
        logic             vm [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic             vd [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [WIDTH-1:0] va [4] = '{32'd5, 32'hFFFFFFFB, 32'd0, 32'd0};
        logic [WIDTH-1:0] vb [4] = '{32'd0, 32'd0, 32'd9, 32'd5};
        logic             vz [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(vm[i], vd[i], ~vm[i] & ~vd[i], va[i], vb[i]);
            wait_done(lat);
            checks++;
            if (lat != 1) begin failures++; $display("FAIL special_latency[%0d] got=%0d exp=1", i, lat); end
            checks++;
            if (imdr_data_out !== '0) begin failures++; $display("FAIL special_data[%0d] got=%h exp=0", i, imdr_data_out); end
            checks++;
            if (imdr_div0_e !== vz[i]) begin failures++; $display("FAIL special_div0[%0d] got=%b exp=%b", i, imdr_div0_e, vz[i]); end
            step();
            checks++;
            if (imdr_busy !== 1'b0 || imdr_div0_e !== 1'b0) begin
                failures++; $display("FAIL special_after[%0d] busy=%b div0=%b exp=0,0", i, imdr_busy, imdr_div0_e);
            end
            // Leave a nonzero result behind so the next zero result is meaningful.
            issue(1'b1, 1'b0, 1'b0, 32'd3, 32'd3);
            wait_done(lat);
            step();
        end
    endtask

    task automatic test_kill();
        int lat;
        int seen;
        issue(1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
        lat = 1;
        while (lat < 9) begin step(); lat++; end
        checks++;
        if (imdr_busy !== 1'b1) begin failures++; $display("FAIL kill_busy_before got=%b exp=1", imdr_busy); end
        kill_inst_e = 1'b1;
        step();
        kill_inst_e = 1'b0;
        checks++;
        if (imdr_busy !== 1'b0) begin failures++; $display("FAIL kill_busy_after got=%b exp=0", imdr_busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (imdr_done_e) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL kill_no_done got=%0d exp=0", seen); end
        issue(1'b1, 1'b0, 1'b0, 32'd6, 32'd7);
        wait_done(lat);
        checks++;
        if (lat != 34) begin failures++; $display("FAIL kill_next_latency got=%0d exp=34", lat); end
        checks++;
        if (imdr_data_out !== 32'd42) begin failures++; $display("FAIL kill_next_data got=%h exp=0000002a", imdr_data_out); end
        step();
        // Kill beats hold.
        issue(1'b1, 1'b0, 1'b0, 32'd5, 32'd5);
        step();
        step();
        kill_inst_e = 1'b1;
        pj_hold     = 1'b1;
        step();
        kill_inst_e = 1'b0;
        pj_hold     = 1'b0;
        checks++;
        if (imdr_busy !== 1'b0) begin failures++; $display("FAIL kill_over_hold busy=%b exp=0", imdr_busy); end
        // A request alongside kill in IDLE is dropped.
        kill_inst_e = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 32'd0, 32'd1);
        kill_inst_e = 1'b0;
        checks++;
        if (imdr_busy !== 1'b0 || imdr_done_e !== 1'b0) begin
            failures++; $display("FAIL kill_drops_req busy=%b done=%b exp=0,0", imdr_busy, imdr_done_e);
        end
    endtask

    task automatic test_hold();
        int lat;
        issue(1'b1, 1'b0, 1'b0, 32'd9, 32'hFFFFFFFB);
        lat = 1;
        while (!imdr_done_e && lat < 100) begin
            if (lat == 5)  pj_hold = 1'b1;
            if (lat == 10) pj_hold = 1'b0;
            step();
            lat++;
        end
        checks++;
        if (lat != 39) begin failures++; $display("FAIL hold_latency got=%0d exp=39", lat); end
        checks++;
        if (imdr_data_out !== 32'hFFFFFFD3) begin failures++; $display("FAIL hold_data got=%h exp=ffffffd3", imdr_data_out); end
        pj_hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (imdr_done_e !== 1'b1 || imdr_data_out !== 32'hFFFFFFD3) begin
                failures++; $display("FAIL hold_done_stretch[%0d] done=%b data=%h exp=1,ffffffd3", i, imdr_done_e, imdr_data_out);
            end
        end
        pj_hold = 1'b0;
        step();
        checks++;
        if (imdr_done_e !== 1'b0) begin failures++; $display("FAIL hold_done_release got=%b exp=0", imdr_done_e); end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
        checks++;
        if (imdr_done_e !== 1'b1) begin failures++; $display("FAIL b2b_first_done got=%b exp=1", imdr_done_e); end
        // Request presented during DONE is ignored, then accepted in IDLE.
        issue(1'b1, 1'b0, 1'b0, 32'd2, 32'd3);
        checks++;
        if (imdr_busy !== 1'b0) begin failures++; $display("FAIL b2b_done_ignored busy=%b exp=0", imdr_busy); end
        issue(1'b1, 1'b0, 1'b0, 32'd2, 32'd3);
        wait_done(lat);
        checks++;
        if (lat != 34 || imdr_data_out !== 32'd6) begin
            failures++; $display("FAIL b2b_second lat=%0d data=%h exp=34,00000006", lat, imdr_data_out);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        int seen;
        issue(1'b0, 1'b1, 1'b0, 32'd100, 32'd3);
        step();
        step();
        reset_l = 1'b0;
        step();
        reset_l = 1'b1;
        checks++;
        if (imdr_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", imdr_busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (imdr_done_e) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen); end
    endtask

    task automatic test_unsigned();
        int lat;
        logic [WIDTH-1:0] exp_q;
`ifdef IMDR_GEN_UNSIGNED_EN
        exp_q = 32'h7FFFFFFF;
`else
        exp_q = 32'd0;
`endif
        ie_unsigned_d = 1'b1;
        issue(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd2);
        ie_unsigned_d = 1'b0;
        wait_done(lat);
        checks++;
        if (lat != 34 || imdr_data_out !== exp_q) begin
            failures++; $display("FAIL unsigned_div lat=%0d data=%h exp=34,%h", lat, imdr_data_out, exp_q);
        end
        step();
    endtask

    initial begin
        reset_l       = 1'b0;
        ie_mul_d      = 1'b0;
        ie_div_d      = 1'b0;
        ie_rem_d      = 1'b0;
        ie_unsigned_d = 1'b0;
        ie_dataA_d    = '0;
        ie_dataB_d    = '0;
        kill_inst_e   = 1'b0;
        pj_hold       = 1'b0;
        @(negedge clk);
        test_reset();
        test_mul();
        test_divrem();
        test_special();
        test_kill();
        test_hold();
        test_back_to_back();
        test_reset_mid_op();
        test_unsigned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
